// File: rtl/frac_clk_gen.sv
// Multi-channel fractional clock-enable generator.
// Each channel is a phase accumulator: the carry out of acc + inc gives a
// one-cycle enable pulse, and the accumulator MSB gives a ~50 % square wave.
// Increments are reloaded via a valid/ready port. A new increment is staged
// and swapped in only on a wrap, so the output phase stays continuous.
module frac_clk_gen #(
  parameter int                       NUM_CH      = 2,
  parameter int                       ACC_W       = 32,
  parameter int                       LOCK_CYCLES = 1024,
  parameter logic [NUM_CH*ACC_W-1:0]  INC_INIT    = {NUM_CH{32'h4072_B021}},
  localparam int                      CH_W        = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              clk_in1,
  input  logic              reset,
  input  logic [NUM_CH-1:0] en,
  input  logic              cfg_valid,
  input  logic [CH_W-1:0]   cfg_ch,
  input  logic [ACC_W-1:0]  cfg_inc,
  output logic              cfg_ready,
  output logic [NUM_CH-1:0] ce,
  output logic [NUM_CH-1:0] clk_sq,
  output logic              locked
);

  localparam int LCW = $clog2(LOCK_CYCLES + 1);

  // Per-channel state
  logic [ACC_W-1:0] acc      [NUM_CH];
  logic [ACC_W-1:0] inc      [NUM_CH];
  logic [ACC_W-1:0] pend_inc [NUM_CH];
  logic [NUM_CH-1:0] pend;

  // Per-channel combinational terms
  logic [ACC_W:0]    sum [NUM_CH];
  logic [NUM_CH-1:0] carry;
  logic [NUM_CH-1:0] apply;
  logic [NUM_CH-1:0] accept;

  // Startup settle counter
  logic [LCW-1:0] lock_cnt;
  logic [LCW-1:0] lock_cnt_next;

  // Ready is low only while the addressed channel still holds an unapplied
  // update; an out-of-range channel is always ready and simply ignored.
  always_comb begin
    // NOTE: every signal written in always_comb gets a default first, so no
    // path through the block leaves it unassigned and no latch is inferred.
    cfg_ready = 1'b1;
    for (int i = 0; i < NUM_CH; i++) begin
      if (cfg_ch == CH_W'(i)) cfg_ready = ~pend[i];
    end
  end

  // Phase add, wrap detection, and the accept/apply decisions per channel.
  // A zero increment or a disabled channel also releases a staged update,
  // so an update can never wait forever for a wrap that will not come.
  always_comb begin
    for (int i = 0; i < NUM_CH; i++) begin
      sum[i]    = {1'b0, acc[i]} + {1'b0, inc[i]};
      carry[i]  = en[i] & sum[i][ACC_W];
      apply[i]  = pend[i] & (carry[i] | ~en[i] | (inc[i] == '0));
      accept[i] = cfg_valid & cfg_ready & (cfg_ch == CH_W'(i));
    end
  end

  // Accumulators, increment staging and registered outputs.
  always_ff @(posedge clk_in1 or posedge reset) begin
    if (reset) begin
      // NOTE: these arrays are a handful of flops per channel, not a RAM, so
      // resetting them costs nothing and gives a known phase after reset.
      for (int i = 0; i < NUM_CH; i++) begin
        acc[i]      <= '0;
        inc[i]      <= INC_INIT[i*ACC_W +: ACC_W];
        pend_inc[i] <= '0;
      end
      pend   <= '0;
      ce     <= '0;
      clk_sq <= '0;
    end else begin
      // NOTE: non-blocking assignments here, so every channel sees the
      // pre-edge values of acc/inc/pend regardless of statement order.
      for (int i = 0; i < NUM_CH; i++) begin
        if (en[i]) begin
          acc[i]    <= sum[i][ACC_W-1:0];
          ce[i]     <= sum[i][ACC_W];
          clk_sq[i] <= sum[i][ACC_W-1];
        end else begin
          acc[i]    <= '0;
          ce[i]     <= 1'b0;
          clk_sq[i] <= 1'b0;
        end
        // The add on the applying edge already used the old inc above.
        if (apply[i]) begin
          inc[i]  <= pend_inc[i];
          pend[i] <= 1'b0;
        end
        if (accept[i]) begin
          pend_inc[i] <= cfg_inc;
          pend[i]     <= 1'b1;
        end
      end
    end
  end

  // Saturating count of edges since reset release.
  always_comb begin
    lock_cnt_next = lock_cnt;
    if (lock_cnt != LCW'(LOCK_CYCLES)) lock_cnt_next = lock_cnt + LCW'(1);
  end

  // Lock status: settled for LOCK_CYCLES edges and nothing staged.
  always_ff @(posedge clk_in1 or posedge reset) begin
    if (reset) begin
      lock_cnt <= '0;
      locked   <= 1'b0;
    end else begin
      lock_cnt <= lock_cnt_next;
      locked   <= (lock_cnt_next == LCW'(LOCK_CYCLES)) && !(|pend);
    end
  end

endmodule

// File: tb/tb_frac_clk_gen.sv
// Self-checking bench for frac_clk_gen. Three channels are instantiated so
// that the 2-bit channel select can address a channel that does not exist.
module tb_frac_clk_gen;

  localparam int          NCH  = 3;
  localparam int          LOCK = 1024;
  localparam logic [31:0] INC0 = 32'h4072_B021;

  logic            clk_in1 = 1'b0;
  logic            reset;
  logic [NCH-1:0]  en;
  logic            cfg_valid;
  logic [1:0]      cfg_ch;
  logic [31:0]     cfg_inc;
  logic            cfg_ready;
  logic [NCH-1:0]  ce;
  logic [NCH-1:0]  clk_sq;
  logic            locked;

  int n_checks = 0;
  int n_fail   = 0;

  frac_clk_gen #(.NUM_CH(NCH), .ACC_W(32), .LOCK_CYCLES(LOCK)) dut (
    .clk_in1  (clk_in1),
    .reset    (reset),
    .en       (en),
    .cfg_valid(cfg_valid),
    .cfg_ch   (cfg_ch),
    .cfg_inc  (cfg_inc),
    .cfg_ready(cfg_ready),
    .ce       (ce),
    .clk_sq   (clk_sq),
    .locked   (locked)
  );

  always #5 clk_in1 = ~clk_in1;

  // ---------------------------------------------------------------------
  // Reference model: phase as an integer in [0, 2^32), wrap when the
  // running sum reaches 2^32; staged rate swapped on wrap/disable/zero rate.
  // ---------------------------------------------------------------------
  longint unsigned m_acc  [NCH];
  longint unsigned m_rate [NCH];
  longint unsigned m_next [NCH];
  bit [NCH-1:0]    m_wait;
  bit [NCH-1:0]    m_ce;
  bit [NCH-1:0]    m_sq;
  int              m_cnt;
  bit              m_locked;
  longint unsigned total;
  bit              wrapped;
  bit              was_waiting;

  always @(posedge clk_in1 or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NCH; i++) begin
        m_acc[i]  = 0;
        m_rate[i] = INC0;
        m_next[i] = 0;
      end
      m_wait = '0; m_ce = '0; m_sq = '0; m_cnt = 0; m_locked = 0;
    end else begin
      was_waiting = |m_wait;
      for (int i = 0; i < NCH; i++) begin
        wrapped = 0;
        if (en[i]) begin
          total    = m_acc[i] + m_rate[i];
          wrapped  = total >= 64'h1_0000_0000;
          m_acc[i] = total % 64'h1_0000_0000;
          m_ce[i]  = wrapped;
          m_sq[i]  = m_acc[i] >= 64'h8000_0000;
        end else begin
          m_acc[i] = 0; m_ce[i] = 0; m_sq[i] = 0;
        end
        if (m_wait[i]) begin
          if (wrapped || !en[i] || m_rate[i] == 0) begin
            m_rate[i] = m_next[i];
            m_wait[i] = 0;
          end
        end else if (cfg_valid && cfg_ch == i) begin
          m_next[i] = cfg_inc;
          m_wait[i] = 1;
        end
      end
      if (m_cnt < LOCK) m_cnt++;
      m_locked = (m_cnt == LOCK) && !was_waiting;
    end
  end

  function automatic bit m_ready();
    if (cfg_ch >= NCH) return 1'b1;
    return !m_wait[cfg_ch];
  endfunction

  // ---------------------------------------------------------------------
  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_in1);
    #1;
  endtask

  task automatic drive(input logic [NCH-1:0] e, input logic v, input logic [1:0] c, input logic [31:0] n);
    en = e; cfg_valid = v; cfg_ch = c; cfg_inc = n;
  endtask

  // Release reset and verify lock timing plus pulse count from phase 0.
  task automatic lock_run(input logic [NCH-1:0] e, input int n_edges, input string tag);
    int pulses;
    pulses = 0;
    @(posedge clk_in1); #1;
    reset = 1'b0;
    drive(e, 1'b0, 2'd0, 32'h0);
    for (int k = 1; k <= n_edges; k++) begin
      tick();
      if (ce[0]) pulses++;
      if (k == LOCK - 1) check({tag, "_locked_before"}, locked, 1'b0);
      if (k == LOCK) begin
        check({tag, "_locked_at"}, locked, 1'b1);
        check({tag, "_ce_count_1024"}, pulses, (longint'(LOCK) * INC0) >> 32);
      end
    end
    if (n_edges == 20000) begin
      // 20 000 cycles at 25.175 MHz / 100 MHz -> 5035 pulses, +-1
      n_checks++;
      if (pulses < 5034 || pulses > 5036) begin
        n_fail++;
        $display("FAIL %s_ce_count_20000: got %0d, expected 5035 +-1", tag, pulses);
      end
    end
  endtask

  typedef struct {
    logic [NCH-1:0] en;
    logic           valid;
    logic [1:0]     ch;
    logic [31:0]    inc;
    logic           exp_ready;
    logic           exp_ce;
    logic           exp_sq;
  } vec_t;

  vec_t vecs [10];

  // Hard bound on total run time.
  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int  cnt;
    bit  seen;
    logic [31:0] r;

    // Rows: inputs before the edge, ready seen before it, ce0/sq0 after it.
    vecs[0] = '{3'b000, 1'b1, 2'd0, 32'h4000_0000, 1'b1, 1'b0, 1'b0};
    vecs[1] = '{3'b000, 1'b0, 2'd0, 32'h0,         1'b0, 1'b0, 1'b0};
    vecs[2] = '{3'b001, 1'b0, 2'd0, 32'h0,         1'b1, 1'b0, 1'b0};
    vecs[3] = '{3'b001, 1'b0, 2'd0, 32'h0,         1'b1, 1'b0, 1'b1};
    vecs[4] = '{3'b001, 1'b0, 2'd0, 32'h0,         1'b1, 1'b0, 1'b1};
    vecs[5] = '{3'b001, 1'b0, 2'd0, 32'h0,         1'b1, 1'b1, 1'b0};
    vecs[6] = '{3'b001, 1'b0, 2'd0, 32'h0,         1'b1, 1'b0, 1'b0};
    vecs[7] = '{3'b001, 1'b0, 2'd0, 32'h0,         1'b1, 1'b0, 1'b1};
    vecs[8] = '{3'b001, 1'b0, 2'd0, 32'h0,         1'b1, 1'b0, 1'b1};
    vecs[9] = '{3'b001, 1'b0, 2'd0, 32'h0,         1'b1, 1'b1, 1'b0};

    // ---- Reset values, lock timing, default rate ----
    reset = 1'b1;
    drive('0, 1'b0, 2'd0, 32'h0);
    #12;
    check("rst_ce", ce, 0);
    check("rst_clk_sq", clk_sq, 0);
    check("rst_locked", locked, 0);
    check("rst_cfg_ready", cfg_ready, 1);
    lock_run(3'b001, 20000, "init");

    // ---- Table: ch0 at 1/4 rate from phase 0 ----
    @(posedge clk_in1); #1;
    reset = 1'b1;
    #2;
    @(posedge clk_in1); #1;
    reset = 1'b0;
    foreach (vecs[i]) begin
      drive(vecs[i].en, vecs[i].valid, vecs[i].ch, vecs[i].inc);
      #1;
      check($sformatf("vec%0d_ready", i), cfg_ready, vecs[i].exp_ready);
      tick();
      check($sformatf("vec%0d_ce0", i), ce[0], vecs[i].exp_ce);
      check($sformatf("vec%0d_sq0", i), clk_sq[0], vecs[i].exp_sq);
    end
    drive(3'b001, 1'b0, 2'd0, 32'h0);
    repeat (1100) tick();
    check("settled_locked", locked, 1);

    // ---- ch1: 1/4 rate, then reprogram to 1/2 mid-period ----
    drive(3'b001, 1'b1, 2'd1, 32'h4000_0000);
    tick();
    drive(3'b001, 1'b0, 2'd1, 32'h0);
    repeat (3) tick();
    drive(3'b011, 1'b0, 2'd1, 32'h0);
    for (int k = 1; k <= 6; k++) begin
      tick();
      check($sformatf("ch1_q_edge%0d", k), ce[1], k == 4);
    end
    drive(3'b011, 1'b1, 2'd1, 32'h8000_0000);
    #1 check("ch1_upd_ready_idle", cfg_ready, 1);
    tick();                                        // edge 7: accept
    check("ch1_e7_ce", ce[1], 0);
    check("ch1_e7_locked", locked, 1);
    drive(3'b011, 1'b1, 2'd1, 32'h1234_5678);      // second request while staged
    #1 check("ch1_busy_ready", cfg_ready, 0);
    tick();                                        // edge 8: wrap, apply
    check("ch1_e8_ce_old_spacing", ce[1], 1);
    check("ch1_e8_locked_low", locked, 0);
    drive(3'b011, 1'b0, 2'd1, 32'h0);
    #1 check("ch1_ready_back", cfg_ready, 1);
    tick();
    check("ch1_e9_ce", ce[1], 0);
    check("ch1_e9_locked_back", locked, 1);
    tick(); check("ch1_e10_ce", ce[1], 1);
    tick(); check("ch1_e11_ce", ce[1], 0);
    tick(); check("ch1_e12_ce", ce[1], 1);

    // ---- Out-of-range channel: accepted and discarded ----
    drive(3'b011, 1'b1, 2'd3, 32'h0);
    #1 check("ch3_ready", cfg_ready, 1);
    tick();
    check("ch3_e13_ce1", ce[1], 0);
    drive(3'b011, 1'b0, 2'd0, 32'h0);
    #1 check("ch3_ch0_ready", cfg_ready, 1);
    tick();
    check("ch3_e14_ce1", ce[1], 1);
    check("ch3_locked", locked, 1);
    cfg_ch = 2'd1;
    #1 check("ch3_ch1_ready", cfg_ready, 1);

    // ---- ch0 to zero rate, then release with 1/8 rate ----
    drive(3'b011, 1'b1, 2'd0, 32'h0);
    tick();
    drive(3'b011, 1'b0, 2'd0, 32'h0);
    seen = 0;
    for (int k = 0; k < 8 && !seen; k++) begin
      tick();
      seen = ce[0];
    end
    check("zero_apply_wrap_seen", seen, 1);
    cnt = 0;
    for (int k = 0; k < 20; k++) begin
      tick();
      if (ce[0] || clk_sq[0]) cnt++;
    end
    check("zero_rate_quiet", cnt, 0);
    drive(3'b011, 1'b1, 2'd0, 32'h2000_0000);
    #1 check("zero_upd_ready", cfg_ready, 1);
    tick();                                        // edge A: accept
    drive(3'b011, 1'b0, 2'd0, 32'h0);
    tick();                                        // edge A+1: applied
    check("zero_applied_ready", cfg_ready, 1);
    check("zero_applied_locked", locked, 0);
    for (int j = 2; j <= 9; j++) begin
      tick();
      check($sformatf("eighth_ce_A%0d", j), ce[0], j == 9);
      if (j == 2) check("eighth_locked", locked, 1);
    end

    // ---- Asynchronous reset during a pulse ----
    seen = 0;
    for (int k = 0; k < 16 && !seen; k++) begin
      tick();
      seen = ce[0];
    end
    check("pre_reset_pulse_seen", seen, 1);
    #2 reset = 1'b1;
    #1;
    check("async_rst_ce", ce, 0);
    check("async_rst_clk_sq", clk_sq, 0);
    check("async_rst_locked", locked, 0);
    tick();
    lock_run(3'b011, LOCK, "rerst");

    // ---- Randomized run against the reference model ----
    for (int it = 0; it < 4000; it++) begin
      for (int i = 0; i < NCH; i++) en[i] = ($urandom_range(0, 15) != 0);
      cfg_valid = ($urandom_range(0, 3) == 0);
      cfg_ch    = 2'($urandom_range(0, 3));
      case ($urandom_range(0, 5))
        0: r = 32'h0;
        1: r = 32'hFFFF_FFFF;
        2: r = 32'h8000_0000;
        3: r = $urandom() >> $urandom_range(0, 4);
        default: r = $urandom();
      endcase
      cfg_inc = r;
      #1 check("rnd_ready", cfg_ready, m_ready());
      tick();
      check("rnd_ce", ce, m_ce);
      check("rnd_clk_sq", clk_sq, m_sq);
      check("rnd_locked", locked, m_locked);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
